// File: rtl/logo_writer.sv
// Logo bitmap loader: accepts a packed 1-bpp bitmap over a valid/ready byte
// stream, stores it in a byte memory, and serves registered pixel reads.
module logo_writer #(
  parameter int WIDTH  = 80,
  parameter int HEIGHT = 96
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  input  logic [9:0] x_img,
  input  logic [9:0] y_img,
  output logic       pixel
);

  localparam int BPR   = (WIDTH + 7) / 8;
  localparam int DEPTH = HEIGHT * BPR;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(BPR + 1);
  localparam int RW    = $clog2(HEIGHT + 1);

  localparam logic [AW-1:0] BPR_A    = AW'(BPR);
  localparam logic [CW-1:0] COL_LAST = CW'(BPR - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col_byte;
  logic [RW-1:0] row;
  logic [7:0]    mem [DEPTH];

  logic          accept;
  logic          in_range;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_bit;

  function automatic logic [AW-1:0] byte_addr(input logic [AW-1:0] r,
                                              input logic [AW-1:0] c);
    return r * BPR_A + c;
  endfunction

  // A start in LOAD wins over any byte offered in the same cycle.
  assign in_ready = (state == LOAD) && !start;
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;

  assign wr_addr  = byte_addr(AW'(row), AW'(col_byte));
  assign in_range = (int'(x_img) < WIDTH) && (int'(y_img) < HEIGHT);
  assign rd_addr  = in_range ? byte_addr(AW'(y_img), AW'(x_img[9:3])) : '0;
  assign rd_bit   = ~x_img[2:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      col_byte <= '0;
      row      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            col_byte <= '0;
            row      <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (start) begin
            col_byte <= '0;
            row      <= '0;
          end else if (in_valid) begin
            if (col_byte == COL_LAST) begin
              col_byte <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= DONE;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col_byte <= col_byte + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is never cleared; a reset edge only suppresses the write.
  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pixel <= 1'b0;
    end else begin
      pixel <= in_range && mem[rd_addr][rd_bit];
    end
  end

endmodule

// File: tb/tb_logo_writer.sv
// Directed bench for logo_writer: frame loads, backpressure, restart, reset
// abort and pixel reads checked against a byte-level reference memory.
module tb_logo_writer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [9:0] x_img = '0;
  logic [9:0] y_img = '0;
  logic       pixel;

  logo_writer #(.WIDTH(80), .HEIGHT(96)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done),
    .x_img(x_img), .y_img(y_img), .pixel(pixel)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int widx = 0;
  logic [7:0] refmem [960];

  typedef struct {
    int    x;
    int    y;
    logic  exp;
    string name;
  } vec_t;
  vec_t tbl [13];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic ref_pix(input int x, input int y);
    logic [7:0] b;
    if (x >= 80 || y >= 96) return 1'b0;
    b = refmem[y*10 + x/8];
    return b[7 - x%8];
  endfunction

  task automatic pulse_start(input logic v, input logic [7:0] d, input string name);
    @(negedge clk);
    start = 1'b1; in_valid = v; in_data = d;
    start_cyc = cyc; widx = 0;
    #1;
    check(name, int'(in_ready), 0);
  endtask

  // mode 0: byte k = k[7:0], valid held; mode 1: random valid and data; mode 2: fixed byte
  task automatic stream(input int n, input int mode, input logic [7:0] fixed, input string name);
    int acc = 0;
    int budget = 0;
    logic [7:0] d;
    logic v;
    while (acc < n && budget < 5000) begin
      @(negedge clk);
      start = 1'b0;
      budget++;
      v = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      d = (mode == 0) ? widx[7:0] : (mode == 1) ? 8'($urandom) : fixed;
      in_valid = v; in_data = d;
      #1;
      if (v && in_ready && widx < 960) begin
        refmem[widx] = d;
        widx++;
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    check({name, "_accepts"}, acc, n);
  endtask

  task automatic rd(input int x, input int y, input logic exp, input string name);
    @(negedge clk);
    x_img = 10'(x); y_img = 10'(y);
    @(negedge clk);
    check(name, int'(pixel), int'(exp));
  endtask

  task automatic sweep(input string name);
    int bad = 0;
    logic e_prev = 1'b0;
    bit first = 1'b1;
    for (int y = 0; y < 96; y++) begin
      for (int x = 0; x < 80; x++) begin
        @(negedge clk);
        if (!first && pixel !== e_prev) bad++;
        first = 1'b0;
        x_img = 10'(x); y_img = 10'(y);
        e_prev = ref_pix(x, y);
      end
    end
    @(negedge clk);
    if (pixel !== e_prev) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < 960; i++) refmem[i] = 8'h00;

    tbl[0]  = '{0,    0,    1'b0, "px0_0"};
    tbl[1]  = '{8,    0,    1'b0, "px8_0"};
    tbl[2]  = '{15,   0,    1'b1, "px15_0"};
    tbl[3]  = '{68,   0,    1'b1, "px68_0"};
    tbl[4]  = '{71,   0,    1'b0, "px71_0"};
    tbl[5]  = '{6,    1,    1'b1, "px6_1"};
    tbl[6]  = '{7,    1,    1'b0, "px7_1"};
    tbl[7]  = '{0,    95,   1'b1, "px0_95"};
    tbl[8]  = '{72,   95,   1'b1, "px72_95"};
    tbl[9]  = '{79,   95,   1'b1, "px79_95"};
    tbl[10] = '{80,   0,    1'b0, "oob80_0"};
    tbl[11] = '{0,    96,   1'b0, "oob0_96"};
    tbl[12] = '{1023, 1023, 1'b0, "oob1023"};

    // Reset held with a byte on offer
    rstn = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pixel", int'(pixel), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    rd(0, 0, 1'b0, "rst_nowrite");

    // Full frame, byte k = k[7:0]
    done_cnt = 0;
    pulse_start(1'b0, 8'h00, "f1_start_rdy");
    stream(960, 0, 8'h00, "f1");
    repeat (3) @(negedge clk);
    check("f1_done_cnt", done_cnt, 1);
    check("f1_done_cycle", done_cyc - start_cyc, 961);
    for (int i = 0; i < 13; i++) rd(tbl[i].x, tbl[i].y, tbl[i].exp, tbl[i].name);
    sweep("f1_sweep");

    // Random gaps in in_valid
    done_cnt = 0;
    pulse_start(1'b0, 8'h00, "f2_start_rdy");
    stream(960, 1, 8'h00, "f2");
    repeat (3) @(negedge clk);
    check("f2_done_cnt", done_cnt, 1);
    sweep("f2_sweep");

    // Restart after 100 bytes, then an all-ones frame
    done_cnt = 0;
    pulse_start(1'b0, 8'h00, "f3_start_rdy");
    stream(100, 0, 8'h00, "f3a");
    check("f3_busy_mid", int'(busy), 1);
    pulse_start(1'b1, 8'h33, "restart_rdy");
    stream(960, 2, 8'hFF, "f3b");
    repeat (3) @(negedge clk);
    check("f3_done_cnt", done_cnt, 1);
    rd(80, 0, 1'b0, "ff_oob80_0");
    rd(0, 96, 1'b0, "ff_oob0_96");
    rd(1023, 1023, 1'b0, "ff_oob1023");
    rd(79, 95, 1'b1, "ff_px79_95");
    sweep("f3_sweep");

    // Same-edge read/write, write latency, then reset mid-load
    done_cnt = 0;
    pulse_start(1'b0, 8'h00, "f4_start_rdy");
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    x_img = 10'd0; y_img = 10'd0;
    #1;
    check("f4_in_ready", int'(in_ready), 1);
    check("f4_busy", int'(busy), 1);
    refmem[0] = 8'h00;
    widx = 1;
    @(negedge clk);
    in_valid = 1'b0;
    check("same_edge_old", int'(pixel), 1);
    @(negedge clk);
    check("write_latency", int'(pixel), 0);
    stream(49, 2, 8'h00, "f4");
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_pixel", int'(pixel), 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hAA;
      #1;
      if (in_ready !== 1'b0) bad++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_no_accept", bad, 0);
    check("abort_done_cnt", done_cnt, 0);
    sweep("f4_sweep");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logo_writer.md
# logo_writer

Byte-stream loader and pixel store for the screen-saver logo. Accepts a packed 1-bit-per-pixel bitmap over a valid/ready byte stream and writes it into an internal bitmap memory. The memory serves registered B&W pixel reads by image coordinate to the renderer, so the logo can be replaced at run time instead of being fixed at synthesis.

## Interface

Parameters:
- `WIDTH`, 80: image width in pixels.
- `HEIGHT`, 96: image height in pixels.
- Derived, not overridable: `BPR = ceil(WIDTH/8)` bytes per row; `DEPTH = HEIGHT*BPR` bytes of storage.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `start` input 1: pulse; begins (or restarts) a frame load.
- `in_data` input 8: bitmap byte; MSB is the leftmost pixel.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block accepts a byte this cycle.
- `busy` output 1: frame load in progress.
- `done` output 1: one-cycle pulse when a full frame has been written.
- `x_img` input 10: read X coordinate.
- `y_img` input 10: read Y coordinate.
- `pixel` output 1: registered pixel at (`x_img`, `y_img`).

## Operation

- Storage: byte memory `mem[DEPTH]` of 8 bits, byte address `y*BPR + (x>>3)`, pixel bit `7-(x&7)`. Contents are zero at configuration. Reset does not clear the memory.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: `in_ready=0`, `busy=0`. If `start=1`, clear `col_byte` (0..BPR-1) and `row` (0..HEIGHT-1), then go to LOAD.
  - LOAD: `in_ready=1`, `busy=1`. On `in_valid & in_ready`, write `in_data` to address `row*BPR + col_byte`.
    - If `col_byte = BPR-1`: clear `col_byte` and increment `row`. Otherwise increment `col_byte`.
    - When the accepted byte has `row=HEIGHT-1` and `col_byte=BPR-1`, go to DONE.
  - DONE: `done=1`, `in_ready=0`, `busy=0`. Go to IDLE on the next cycle.
- `start=1` while in LOAD restarts the load: counters clear to 0 and the state stays LOAD. A byte presented in the same cycle is not accepted, because `in_ready` is forced to 0 in that cycle.
- `start=1` while in DONE is ignored. It is honoured only in IDLE or LOAD.
- Padding: when `WIDTH%8 != 0`, the low-order bits of the last byte in each row are stored but never read.
- Read port:
  - If `x_img < WIDTH` and `y_img < HEIGHT`: `pixel <= mem[y_img*BPR + (x_img>>3)][7-(x_img[2:0])]`.
  - Otherwise: `pixel <= 0`.
  - Reads are active in every state, including during a load. Partially loaded frames are visible.
- Address arithmetic is unsigned. The width is `ceil(log2(DEPTH))`; 10 bits at the defaults (DEPTH=960). The products `y*BPR` are computed only for in-range coordinates.

## Timing

- Reset (`rstn=0` at a clock edge): state IDLE, `in_ready=0`, `busy=0`, `done=0`, `pixel=0`, counters 0.
- Reset asserted mid-load aborts the load. Bytes already written remain in memory.
- `in_ready` is a decode of the registered state and does not depend on `in_valid`.
- `start` is sampled in cycle N. LOAD, and therefore `in_ready=1`, begins in cycle N+1.
- Throughput in LOAD is one byte per cycle. A full frame takes at least DEPTH cycles in LOAD.
- `done` is high exactly one cycle: the cycle after the final byte is accepted.
- Write latency: a byte accepted at edge N is readable by a read address applied for edge N+1.
- A read and write to the same byte address at the same edge return the old data.
- Read latency is 1 cycle: the coordinate is sampled at edge N and `pixel` is valid after edge N.

## Test plan

- Reset, then idle. Hold `rstn=0` for 2 cycles with `in_valid=1`. Required: `in_ready`, `busy`, `done` and `pixel` all 0; no memory write occurs (reading (0,0) returns 0).
- Full frame. Pulse `start`, then stream 960 bytes with `in_valid` held at 1 and byte k = k[7:0].
  - `done` pulses exactly once, 961 cycles after the `start` edge (960 accept cycles plus 1).
  - Pixel (8,0) reads bit 7 of byte 1, which is 0. Pixel (15,0) reads bit 0 of byte 1, which is 1.
  - Pixel (0,95) reads bit 7 of byte 950 (0xB6), which is 1.
- Backpressure and gaps. Toggle `in_valid` randomly across a full frame. Required: exactly 960 accepts; `done` fires once; memory matches the reference model.
- Out-of-range read. Apply x=80,y=0 and x=0,y=96 and x=1023,y=1023 after the load. Required: `pixel=0` one cycle later in every case.
- Restart mid-load. After 100 accepted bytes, pulse `start`, then send 960 bytes of 0xFF.
  - `in_ready=0` in the restart cycle.
  - All in-range pixels read 1 afterwards.
  - `done` fires once, for the second load only.
- Reset mid-load. Drive `rstn=0` after 50 bytes. Required: state returns to IDLE with `busy=0`; the 50 written bytes are intact; further `in_valid` is not accepted until a new `start`.
